math_adder_brent_kung_pipe: RTL and testbench
=============================================

# math_adder_brent_kung_pipe

Parametrised, pipelined Brent-Kung adder/subtractor with a valid/ready stream interface. It generalises the fixed 32-bit Brent-Kung group-PG prefix network to any power-of-two width N. A per-level register mask places pipeline registers between prefix levels, and the pipeline stalls globally under downstream backpressure. It sits in the common math library as the drop-in wide adder for datapaths that need to close timing at high clock rates.

## Interface
Parameters:
- N, default 32: operand width; power of two, 8..128.
- REG_LEVELS, default all-zero: bit mask of width 2*log2(N)-1. Bit k=1 inserts a register after prefix level k.
  - Levels 0..log2(N)-1 are up-sweep.
  - Levels log2(N)..2*log2(N)-2 are down-sweep.

Ports:
- i_clk  in  1  clock; all state on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_valid  in  1  operand beat valid.
- o_ready  out  1  block accepts a beat this cycle.
- i_a  in  N  operand A.
- i_b  in  N  operand B.
- i_c  in  1  carry-in; ignored when i_sub=1.
- i_sub  in  1  0: A+B+i_c. 1: A+~B+1 (A-B).
- o_valid  out  1  result beat valid.
- i_ready  in  1  downstream accepts result.
- o_sum  out  N  sum/difference.
- o_c  out  1  carry-out (bit N of the prefix).
- o_ovf  out  1  signed overflow, carry(N) XOR carry(N-1).

## Operation
- **Pre-processing** (combinational, at input):
  - b' = i_b ^ {N{i_sub}}; cin = i_sub | i_c.
  - p[0]=0, g[0]=cin; p[k+1]=a[k]^b'[k], g[k+1]=a[k]&b'[k] for k=0..N-1 (N+1-bit PG vectors, bit 0 = carry-in).
- **Prefix network:** standard Brent-Kung.
  - Up-sweep: level j combines spans of 2^(j+1).
  - Down-sweep fills the intermediate carries.
  - Black cells produce (G,P); gray cells produce G only for spans reaching bit 0.
  - Result GG[i] = carry into sum bit i; GG[N] = carry-out.
- **Post-processing:** sum[k] = p[k+1] ^ GG[k]; o_c = GG[N]; o_ovf = GG[N] ^ GG[N-1].
- **Pipeline registers:**
  - At each level k with REG_LEVELS[k]=1, the full PG state (plus the p vector needed for the sum and a stage-valid bit) is registered.
  - The output register (o_sum, o_c, o_ovf, o_valid) always exists.
- **Stall:** global enable en = ~o_valid | i_ready.
  - o_ready = en (combinational from o_valid and i_ready).
  - When en=0, every stage and the output hold their contents.
  - When en=1, all stages shift one slot; an input beat enters iff i_valid & o_ready.
  - Bubbles are not collapsed; empty stages shift as invalid.
- Data registers may be left un-reset; stage-valid bits and output registers are reset.

## Timing
- Latency L = popcount(REG_LEVELS) + 1 cycles, from input handshake to o_valid, with no stall. Default L=1.
- Throughput: one beat per cycle while i_ready=1.
- Reset (i_rst_n=0, async):
  - o_valid=0, o_sum=0, o_c=0, o_ovf=0, all stage valids=0.
  - o_ready=1 immediately after reset.
- Reset mid-operation: all in-flight beats are discarded. No beat emerges after reset release until a new input handshake plus L cycles.
- Holding rules:
  - o_valid=1 with i_ready=0: o_sum/o_c/o_ovf remain stable until the handshake.
  - i_valid may toggle freely; i_a/i_b/i_c/i_sub are sampled only on i_valid & o_ready.
- Simultaneous output handshake and input acceptance is permitted in the same cycle; no throughput loss.
- Wrap-around: the sum is modulo 2^N. Example: all-ones + 1 gives sum 0, o_c=1.

## Test plan
- **Add with carry chain** (N=32, REG_LEVELS=0):
  - A=0xFFFFFFFF, B=0x00000001, i_c=0 -> after 1 cycle o_sum=0x00000000, o_c=1, o_ovf=0.
- **Subtract / signed overflow:**
  - i_sub=1, A=0x80000000, B=0x00000001 -> o_sum=0x7FFFFFFF, o_c=1, o_ovf=1.
  - i_sub=1, A=5, B=7 -> o_sum=0xFFFFFFFE, o_c=0.
- **Deep pipeline** (N=64, REG_LEVELS=all ones, L=12):
  - Back-to-back stream of 100 random beats with i_ready=1 -> results in order, exactly 12 cycles after each input handshake, no gaps.
- **Backpressure:**
  - With L=4, drop i_ready for 5 cycles mid-stream -> o_ready=0 while o_valid=1; o_sum held stable; no beat lost or duplicated; order preserved vs. a software model.
- **Async reset mid-stream:**
  - Assert i_rst_n=0 between clock edges with 3 beats in flight -> o_valid=0 and o_sum=0 immediately; o_ready=1; no stale beats after release.
- **Width sweep:**
  - N in {8,16,32,64,128} with random REG_LEVELS masks, 10k random A/B/i_c/i_sub -> bit-exact against the reference A+B+cin model, including o_c and o_ovf.

Source files
------------

// File: rtl/math_adder_brent_kung_pipe.sv
// math_adder_brent_kung_pipe
//   Pipelined Brent-Kung adder/subtractor with a valid/ready stream interface.
//   The prefix network runs over the N operand positions; the carry-in rides
//   in position 0 of the PG vectors, so GG[i] is the carry into sum bit i.
//   Any prefix level can be followed by a pipeline register (REG_LEVELS mask).
//   The output register always exists. The whole pipeline stalls together
//   under downstream backpressure.
//
// Parameters
//   N          operand width, power of two, 8..128
//   REG_LEVELS bit k = 1 registers the state after prefix level k
//              (levels 0..log2(N)-1 up-sweep, the rest down-sweep)
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), async active-low reset
//   i_valid/o_ready  input beat handshake
//   i_a, i_b         operands
//   i_c              carry-in (ignored when i_sub = 1)
//   i_sub            0: A+B+i_c   1: A-B
//   o_valid/i_ready  result beat handshake
//   o_sum            sum / difference (mod 2^N)
//   o_c              carry-out
//   o_ovf            signed overflow
module math_adder_brent_kung_pipe #(
  parameter int unsigned N = 32,
  parameter logic [2*$clog2(N)-2:0] REG_LEVELS = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_sum,
  output logic         o_c,
  output logic         o_ovf
);

  localparam int unsigned LG = $clog2(N);
  localparam int unsigned NL = 2 * LG - 1;

  logic         en;
  logic [N-1:0] b_x;
  logic         cin;

  // Stage k holds the state entering prefix level k; stage NL is the result.
  // g_s/p_s are the group generate/propagate vectors, pr_s the raw bit
  // propagates kept for the final sum XOR, v_s the stage-valid bit.
  logic [N:0] g_s  [NL+1];
  logic [N:0] p_s  [NL+1];
  logic [N:0] pr_s [NL+1];
  logic       v_s  [NL+1];

  logic         o_valid_d, o_valid_q;
  logic [N-1:0] o_sum_d,   o_sum_q;
  logic         o_c_d,     o_c_q;
  logic         o_ovf_d,   o_ovf_q;

  // Global stall: everything advances only if the output slot frees up.
  always_comb begin
    en  = ~o_valid_q | i_ready;
    b_x = i_b ^ {N{i_sub}};
    cin = i_sub | i_c;
  end

  assign o_ready = en;

  assign g_s[0]  = {i_a & b_x, cin};
  assign p_s[0]  = {i_a ^ b_x, 1'b0};
  assign pr_s[0] = {i_a ^ b_x, 1'b0};
  assign v_s[0]  = i_valid;

  for (genvar k = 0; k < NL; k++) begin : g_lvl
    localparam bit          UP   = (k < LG);
    // Down-sweep level LG+t works at distance 2^(LG-2-t).
    localparam int unsigned J    = UP ? k : (2 * LG - 2 - k);
    localparam int unsigned H    = 2 ** J;
    localparam int unsigned SPAN = 2 ** (J + 1);

    logic [N:0] g_c;
    logic [N:0] p_c;

    for (genvar i = 0; i <= N; i++) begin : g_bit
      // Up-sweep: right end of every SPAN-aligned block.
      // Down-sweep: midpoints of blocks that already have a prefix to their left.
      localparam bit HIT = (i < N) &&
                           (UP ? (((i + 1) % SPAN) == 0)
                               : ((((i + 1) % SPAN) == H) && ((i + 1) > SPAN)));
      // Spans that reach position 0 are complete prefixes: G only.
      localparam bit GRAY = !UP || ((i + 1) == SPAN);

      if (HIT) begin : g_cell
        assign g_c[i] = g_s[k][i] | (p_s[k][i] & g_s[k][i-H]);
        if (GRAY) begin : g_gray
          assign p_c[i] = p_s[k][i];
        end else begin : g_black
          assign p_c[i] = p_s[k][i] & p_s[k][i-H];
        end
      end else begin : g_pass
        assign g_c[i] = g_s[k][i];
        assign p_c[i] = p_s[k][i];
      end
    end

    if (REG_LEVELS[k]) begin : g_reg
      logic [N:0] g_d,  g_q;
      logic [N:0] p_d,  p_q;
      logic [N:0] pr_d, pr_q;
      logic       v_d,  v_q;

      always_comb begin
        g_d  = g_q;
        p_d  = p_q;
        pr_d = pr_q;
        v_d  = v_q;
        if (en) begin
          g_d  = g_c;
          p_d  = p_c;
          pr_d = pr_s[k];
          v_d  = v_s[k];
        end
      end

      // Data is qualified by v_q, so it needs no reset.
      always_ff @(posedge i_clk) begin
        g_q  <= g_d;
        p_q  <= p_d;
        pr_q <= pr_d;
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v_q <= 1'b0;
        end else begin
          v_q <= v_d;
        end
      end

      assign g_s[k+1]  = g_q;
      assign p_s[k+1]  = p_q;
      assign pr_s[k+1] = pr_q;
      assign v_s[k+1]  = v_q;
    end else begin : g_wire
      assign g_s[k+1]  = g_c;
      assign p_s[k+1]  = p_c;
      assign pr_s[k+1] = pr_s[k];
      assign v_s[k+1]  = v_s[k];
    end
  end

  // Position N never enters the network; carry-out is one last gray cell
  // folded into post-processing: GG[N] = g[N] | p[N] & GG[N-1].
  logic [N:0]   gg;
  logic [N:0]   pr;
  logic [N-1:0] sum_c;
  logic         cout_c;
  logic         ovf_c;
  logic         pg_last_unused;

  always_comb begin
    gg     = g_s[NL];
    pr     = pr_s[NL];
    sum_c  = pr[N:1] ^ gg[N-1:0];
    cout_c = gg[N] | (pr[N] & gg[N-1]);
    ovf_c  = cout_c ^ gg[N-1];
  end

  assign pg_last_unused = ^p_s[NL] ^ pr[0];

  always_comb begin
    o_valid_d = o_valid_q;
    o_sum_d   = o_sum_q;
    o_c_d     = o_c_q;
    o_ovf_d   = o_ovf_q;
    if (en) begin
      o_valid_d = v_s[NL];
      if (v_s[NL]) begin
        o_sum_d = sum_c;
        o_c_d   = cout_c;
        o_ovf_d = ovf_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q <= 1'b0;
      o_sum_q   <= '0;
      o_c_q     <= 1'b0;
      o_ovf_q   <= 1'b0;
    end else begin
      o_valid_q <= o_valid_d;
      o_sum_q   <= o_sum_d;
      o_c_q     <= o_c_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_sum   = o_sum_q;
  assign o_c     = o_c_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_math_adder_brent_kung_pipe.sv
// Directed bench for math_adder_brent_kung_pipe: one N=32 instance with no
// prefix registers (L=1) and one with three prefix registers (L=4), sharing
// stimulus. Expected results are hand-computed constants.
module tb_math_adder_brent_kung_pipe;

  localparam int unsigned N   = 32;
  localparam logic [8:0]  RL1 = 9'b000000000;
  localparam logic [8:0]  RL4 = 9'b100010001;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic [N-1:0]  i_a;
  logic [N-1:0]  i_b;
  logic          i_c;
  logic          i_sub;
  logic          i_ready;

  logic          o_ready1, o_valid1, o_c1, o_ovf1;
  logic [N-1:0]  o_sum1;
  logic          o_ready4, o_valid4, o_c4, o_ovf4;
  logic [N-1:0]  o_sum4;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic        vs [8];
  logic [31:0] es [8];
  logic        ec [8];
  logic        eo [8];

  math_adder_brent_kung_pipe #(.N(N), .REG_LEVELS(RL1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready1),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .i_sub   (i_sub),
    .o_valid (o_valid1),
    .i_ready (i_ready),
    .o_sum   (o_sum1),
    .o_c     (o_c1),
    .o_ovf   (o_ovf1)
  );

  math_adder_brent_kung_pipe #(.N(N), .REG_LEVELS(RL4)) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready4),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .i_sub   (i_sub),
    .o_valid (o_valid4),
    .i_ready (i_ready),
    .o_sum   (o_sum4),
    .o_c     (o_c4),
    .o_ovf   (o_ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx);
    i_valid = 1'b1;
    i_a     = va[idx];
    i_b     = vb[idx];
    i_c     = vc[idx];
    i_sub   = vs[idx];
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_a     = 32'hDEADBEEF;
    i_b     = 32'hCAFEF00D;
    i_c     = 1'b1;
    i_sub   = 1'b0;
  endtask

  logic [31:0] q_s [$];
  logic        q_c [$];
  logic        q_o [$];
  logic [31:0] held;
  logic        stalled_prev;
  int          sent;
  int          got;
  int          nstall;

  initial begin
    va[0] = 32'hFFFFFFFF; vb[0] = 32'h00000001; vc[0] = 0; vs[0] = 0; es[0] = 32'h00000000; ec[0] = 1; eo[0] = 0;
    va[1] = 32'h80000000; vb[1] = 32'h00000001; vc[1] = 0; vs[1] = 1; es[1] = 32'h7FFFFFFF; ec[1] = 1; eo[1] = 1;
    va[2] = 32'h00000005; vb[2] = 32'h00000007; vc[2] = 0; vs[2] = 1; es[2] = 32'hFFFFFFFE; ec[2] = 0; eo[2] = 0;
    va[3] = 32'h7FFFFFFF; vb[3] = 32'h00000001; vc[3] = 0; vs[3] = 0; es[3] = 32'h80000000; ec[3] = 0; eo[3] = 1;
    va[4] = 32'h12345678; vb[4] = 32'h9ABCDEF0; vc[4] = 1; vs[4] = 0; es[4] = 32'hACF13569; ec[4] = 0; eo[4] = 0;
    va[5] = 32'h0000000A; vb[5] = 32'h00000003; vc[5] = 1; vs[5] = 1; es[5] = 32'h00000007; ec[5] = 1; eo[5] = 0;
    va[6] = 32'h80000000; vb[6] = 32'h80000000; vc[6] = 0; vs[6] = 0; es[6] = 32'h00000000; ec[6] = 1; eo[6] = 1;
    va[7] = 32'h00000000; vb[7] = 32'h00000000; vc[7] = 1; vs[7] = 0; es[7] = 32'h00000001; ec[7] = 0; eo[7] = 0;

    rst_n   = 1'b0;
    i_ready = 1'b1;
    idle();

    // Reset state
    @(negedge clk);
    chk("rst_valid1", 64'(o_valid1), 64'd0);
    chk("rst_sum1",   64'(o_sum1),   64'd0);
    chk("rst_c1",     64'(o_c1),     64'd0);
    chk("rst_ovf1",   64'(o_ovf1),   64'd0);
    chk("rst_ready1", 64'(o_ready1), 64'd1);
    chk("rst_valid4", 64'(o_valid4), 64'd0);
    chk("rst_sum4",   64'(o_sum4),   64'd0);
    chk("rst_c4",     64'(o_c4),     64'd0);
    chk("rst_ovf4",   64'(o_ovf4),   64'd0);
    chk("rst_ready4", 64'(o_ready4), 64'd1);
    rst_n = 1'b1;

    // Back-to-back directed vectors; L=1 and L=4 exact latency
    for (int t = 0; t <= 12; t++) begin
      chk("dir_valid1", 64'(o_valid1), 64'((t >= 1) && (t <= 8)));
      if ((t >= 1) && (t <= 8)) begin
        chk("dir_sum1", 64'(o_sum1), 64'(es[t-1]));
        chk("dir_c1",   64'(o_c1),   64'(ec[t-1]));
        chk("dir_ovf1", 64'(o_ovf1), 64'(eo[t-1]));
      end
      chk("dir_valid4", 64'(o_valid4), 64'((t >= 4) && (t <= 11)));
      if ((t >= 4) && (t <= 11)) begin
        chk("dir_sum4", 64'(o_sum4), 64'(es[t-4]));
        chk("dir_c4",   64'(o_c4),   64'(ec[t-4]));
        chk("dir_ovf4", 64'(o_ovf4), 64'(eo[t-4]));
      end
      if (t < 8) drive(t);
      else       idle();
      @(negedge clk);
    end

    // Backpressure on the L=4 instance: i_ready low for 5 cycles mid-stream
    sent         = 0;
    got          = 0;
    nstall       = 0;
    stalled_prev = 1'b0;
    held         = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      i_ready = !((cyc >= 6) && (cyc < 11));
      if (sent < 8) drive(sent);
      else          idle();
      #1;
      if (o_valid4 && !i_ready) begin
        nstall++;
        chk("bp_ready_low", 64'(o_ready4), 64'd0);
        if (stalled_prev) chk("bp_hold_sum", 64'(o_sum4), 64'(held));
        held         = o_sum4;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (o_valid4 && i_ready) begin
        chk("bp_expected_beat", 64'(q_s.size() != 0), 64'd1);
        if (q_s.size() != 0) begin
          chk("bp_sum", 64'(o_sum4), 64'(q_s.pop_front()));
          chk("bp_c",   64'(o_c4),   64'(q_c.pop_front()));
          chk("bp_ovf", 64'(o_ovf4), 64'(q_o.pop_front()));
          got++;
        end
      end
      if (i_valid && o_ready4) begin
        q_s.push_back(es[sent]);
        q_c.push_back(ec[sent]);
        q_o.push_back(eo[sent]);
        sent++;
      end
      @(negedge clk);
    end
    i_ready = 1'b1;
    chk("bp_stall_cycles", 64'(nstall), 64'd5);
    chk("bp_sent",         64'(sent),   64'd8);
    chk("bp_got",          64'(got),    64'd8);
    chk("bp_queue_empty",  64'(q_s.size()), 64'd0);

    // Async reset with 3 beats in flight in the L=4 pipeline
    for (int t = 0; t < 3; t++) begin
      drive(t);
      @(negedge clk);
    end
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid4", 64'(o_valid4), 64'd0);
    chk("mrst_sum4",   64'(o_sum4),   64'd0);
    chk("mrst_c4",     64'(o_c4),     64'd0);
    chk("mrst_ready4", 64'(o_ready4), 64'd1);
    chk("mrst_valid1", 64'(o_valid1), 64'd0);
    chk("mrst_sum1",   64'(o_sum1),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      chk("mrst_stale4", 64'(o_valid4), 64'd0);
      chk("mrst_stale1", 64'(o_valid1), 64'd0);
      @(negedge clk);
    end

    // Fresh beat after reset release arrives with full latency
    drive(4);
    @(negedge clk);
    idle();
    for (int t = 1; t <= 4; t++) begin
      if (t == 1) begin
        chk("post_valid1", 64'(o_valid1), 64'd1);
        chk("post_sum1",   64'(o_sum1),   64'(es[4]));
      end
      chk("post_valid4", 64'(o_valid4), 64'(t == 4));
      if (t == 4) begin
        chk("post_sum4", 64'(o_sum4), 64'(es[4]));
        chk("post_c4",   64'(o_c4),   64'(ec[4]));
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
